// File: rtl/pcie_os_tx_if.sv
// Symbol stream from the ordered-set generator toward the lane encoder.
// The master drives the symbol, its K flag and valid. The slave returns ready.
interface pcie_os_tx_if;
  logic [7:0] sym;
  logic       sym_k;
  logic       sym_valid;
  logic       sym_ready;

  modport master (output sym, sym_k, sym_valid, input sym_ready);
  modport slave  (input sym, sym_k, sym_valid, output sym_ready);
endinterface

// File: rtl/pcie_os_tx.sv
// PCIe transmit ordered-set generator. It emits TS1/TS2, SKP, EIOS and logical idle,
// one symbol per cycle, and holds the lane in electrical idle when nothing is requested.
module pcie_os_tx #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   os_req_i,
  input  logic [7:0]   link_num_i,
  input  logic         link_pad_i,
  input  logic [4:0]   lane_num_i,
  input  logic         lane_pad_i,
  input  logic [7:0]   n_fts_i,
  input  logic [7:0]   rate_id_i,
  input  logic [7:0]   train_ctrl_i,
  pcie_os_tx_if.master sym_if,
  output logic         elec_idle_o,
  output logic         os_done_o,
  output logic [7:0]   ts_cnt_o
);

  localparam logic [7:0]  COM      = 8'hBC;
  localparam logic [7:0]  PAD      = 8'hF7;
  localparam logic [7:0]  SKP_SYM  = 8'h1C;
  localparam logic [7:0]  EIDL_SYM = 8'h7C;
  localparam logic [7:0]  TS1_ID   = 8'h4A;
  localparam logic [7:0]  TS2_ID   = 8'h45;
  localparam logic [15:0] SKP_LAST = 16'(SKP_INTERVAL - 1);

  typedef enum logic [2:0] {ST_EI, ST_IDLE, ST_TS, ST_SKP, ST_EIOS} state_t;

  typedef struct packed {
    logic [7:0] link;
    logic       link_pad;
    logic [4:0] lane;
    logic       lane_pad;
    logic [7:0] n_fts;
    logic [7:0] rate;
    logic [7:0] tctl;
  } fields_t;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [15:0] skp_cnt, skp_cnt_nx;
  logic        skp_pend, skp_pend_nx;
  logic        ts2, ts2_nx;
  logic [7:0]  ts_cnt_nx;
  fields_t     fields_q, fields_nx, fields_in;
  logic [7:0]  sym_q;
  logic        sym_k_q, valid_q;
  logic        fire, last, wrap, ts_start, eios_start, ts_inc, done_nx;

  // {k, symbol} for a given position of a given set.
  function automatic logic [8:0] os_symbol(state_t st, logic [3:0] i, logic t2, fields_t f);
    logic [8:0] s;
    s = 9'h000;
    case (st)
      ST_SKP:  s = (i == 4'd0) ? {1'b1, COM} : {1'b1, SKP_SYM};
      ST_EIOS: s = (i == 4'd0) ? {1'b1, COM} : {1'b1, EIDL_SYM};
      ST_TS: begin
        case (i)
          4'd0:    s = {1'b1, COM};
          4'd1:    s = f.link_pad ? {1'b1, PAD} : {1'b0, f.link};
          4'd2:    s = f.lane_pad ? {1'b1, PAD} : {1'b0, 3'b000, f.lane};
          4'd3:    s = {1'b0, f.n_fts};
          4'd4:    s = {1'b0, f.rate};
          4'd5:    s = {1'b0, f.tctl};
          default: s = {1'b0, t2 ? TS2_ID : TS1_ID};
        endcase
      end
      default: s = 9'h000;
    endcase
    return s;
  endfunction

  assign fields_in = '{link: link_num_i, link_pad: link_pad_i, lane: lane_num_i,
                       lane_pad: lane_pad_i, n_fts: n_fts_i, rate: rate_id_i,
                       tctl: train_ctrl_i};

  assign fire = valid_q & sym_if.sym_ready;
  assign last = ((state == ST_TS) && (idx == 4'd15)) ||
                (((state == ST_SKP) || (state == ST_EIOS)) && (idx == 4'd3));
  assign wrap = (skp_cnt == SKP_LAST);

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    skp_cnt_nx  = skp_cnt;
    skp_pend_nx = skp_pend;
    ts2_nx      = ts2;
    ts_start    = 1'b0;
    eios_start  = 1'b0;
    ts_inc      = 1'b0;
    done_nx     = 1'b0;
    if (state == ST_EI) begin
      skp_cnt_nx  = '0;
      skp_pend_nx = 1'b0;
      ts_start    = (os_req_i == 2'd1) || (os_req_i == 2'd2);
    end else if (fire) begin
      if (wrap) begin
        skp_cnt_nx  = '0;
        skp_pend_nx = 1'b1;
      end else begin
        skp_cnt_nx = skp_cnt + 16'd1;
      end
      done_nx = last;
      ts_inc  = last && (state == ST_TS);
      if (last && (state == ST_EIOS)) begin
        state_nx    = ST_EI;
        idx_nx      = '0;
        skp_cnt_nx  = '0;
        skp_pend_nx = 1'b0;
      end else if (last || (state == ST_IDLE)) begin
        // A wrap on this very transfer already counts as pending here.
        idx_nx = '0;
        if (skp_pend || wrap) begin
          state_nx    = ST_SKP;
          skp_pend_nx = 1'b0;
        end else if ((os_req_i == 2'd1) || (os_req_i == 2'd2)) begin
          ts_start = 1'b1;
        end else if (os_req_i == 2'd3) begin
          state_nx   = ST_EIOS;
          eios_start = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end else begin
        idx_nx = idx + 4'd1;
      end
    end
    if (ts_start) begin
      state_nx = ST_TS;
      idx_nx   = '0;
      ts2_nx   = (os_req_i == 2'd2);
    end
  end

  assign fields_nx = ts_start ? fields_in : fields_q;

  always_comb begin
    ts_cnt_nx = ts_cnt_o;
    if (eios_start || (ts_start && (ts2_nx != ts2))) begin
      ts_cnt_nx = '0;
    end else if (ts_inc && (ts_cnt_o != 8'hFF)) begin
      ts_cnt_nx = ts_cnt_o + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_EI;
      idx         <= '0;
      skp_cnt     <= '0;
      skp_pend    <= 1'b0;
      ts2         <= 1'b0;
      ts_cnt_o    <= '0;
      os_done_o   <= 1'b0;
      sym_q       <= '0;
      sym_k_q     <= 1'b0;
      valid_q     <= 1'b0;
      elec_idle_o <= 1'b1;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      skp_cnt     <= skp_cnt_nx;
      skp_pend    <= skp_pend_nx;
      ts2         <= ts2_nx;
      ts_cnt_o    <= ts_cnt_nx;
      os_done_o   <= done_nx;
      {sym_k_q, sym_q} <= os_symbol(state_nx, idx_nx, ts2_nx, fields_nx);
      valid_q     <= (state_nx != ST_EI);
      elec_idle_o <= (state_nx == ST_EI);
    end
  end

  always_ff @(posedge clk_i) begin
    fields_q <= fields_nx;
  end

  assign sym_if.sym       = sym_q;
  assign sym_if.sym_k     = sym_k_q;
  assign sym_if.sym_valid = valid_q;

endmodule

// File: tb/tb_pcie_os_tx.sv
// Randomized bench for pcie_os_tx against a queue-of-symbols reference model.
module tb_pcie_os_tx;
  localparam int SKP_INTERVAL = 40;
  localparam int M_EI = 0, M_IDLE = 1, M_TS = 2, M_SKP = 3, M_EIOS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] os_req = 2'd0;
  logic [7:0] link_num = 8'h12;
  logic       link_pad = 1'b1;
  logic [4:0] lane_num = 5'h03;
  logic       lane_pad = 1'b1;
  logic [7:0] n_fts = 8'h20;
  logic [7:0] rate_id = 8'h02;
  logic [7:0] train_ctrl = 8'h00;
  logic       elec_idle, os_done;
  logic [7:0] ts_cnt;

  pcie_os_tx_if bus();

  pcie_os_tx #(.SKP_INTERVAL(SKP_INTERVAL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .os_req_i(os_req),
    .link_num_i(link_num), .link_pad_i(link_pad),
    .lane_num_i(lane_num), .lane_pad_i(lane_pad),
    .n_fts_i(n_fts), .rate_id_i(rate_id), .train_ctrl_i(train_ctrl),
    .sym_if(bus), .elec_idle_o(elec_idle), .os_done_o(os_done), .ts_cnt_o(ts_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: the set being sent is a queue of {k,sym} still to transfer.
  int         mode;
  logic [8:0] q[$];
  int         xfers;
  bit         pend;
  int         tcnt;
  int         ltype;
  bit         edone;

  task automatic model_reset();
    mode = M_EI; q = {}; xfers = 0; pend = 0; tcnt = 0; ltype = 1; edone = 0;
  endtask

  task automatic start_ts();
    int t;
    t = int'(os_req);
    if (t != ltype) tcnt = 0;
    ltype = t;
    mode = M_TS;
    q = {};
    q.push_back(9'h1BC);
    q.push_back(link_pad ? 9'h1F7 : {1'b0, link_num});
    q.push_back(lane_pad ? 9'h1F7 : {1'b0, 3'b000, lane_num});
    q.push_back({1'b0, n_fts});
    q.push_back({1'b0, rate_id});
    q.push_back({1'b0, train_ctrl});
    for (int i = 0; i < 10; i++) q.push_back((t == 1) ? 9'h04A : 9'h045);
  endtask

  task automatic model_step();
    edone = 0;
    if (mode == M_EI) begin
      if (os_req == 2'd1 || os_req == 2'd2) start_ts();
    end else if (bus.sym_ready) begin
      void'(q.pop_front());
      xfers++;
      if (xfers == SKP_INTERVAL) begin xfers = 0; pend = 1; end
      if (q.size() == 0) begin
        if (mode != M_IDLE) edone = 1;
        if (mode == M_TS && tcnt < 255) tcnt++;
        if (mode == M_EIOS) begin
          mode = M_EI; xfers = 0; pend = 0;
        end else if (pend) begin
          pend = 0; mode = M_SKP;
          q = '{9'h1BC, 9'h11C, 9'h11C, 9'h11C};
        end else if (os_req == 2'd1 || os_req == 2'd2) begin
          start_ts();
        end else if (os_req == 2'd3) begin
          mode = M_EIOS; tcnt = 0;
          q = '{9'h1BC, 9'h17C, 9'h17C, 9'h17C};
        end else begin
          mode = M_IDLE;
          q = '{9'h000};
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("valid", bus.sym_valid, mode != M_EI);
    check("elec_idle", elec_idle, mode == M_EI);
    if (mode != M_EI && q.size() > 0) check("symbol", {bus.sym_k, bus.sym}, q[0]);
    check("os_done", os_done, edone);
    check("ts_cnt", ts_cnt, tcnt);
  endtask

  task automatic cyc(input logic [1:0] req, input int rdy_pct, input bit rnd_fields);
    os_req = req;
    bus.sym_ready = ($urandom_range(99) < rdy_pct);
    if (rnd_fields) begin
      link_num = 8'($urandom); link_pad = 1'($urandom);
      lane_num = 5'($urandom); lane_pad = 1'($urandom);
      n_fts = 8'($urandom); rate_id = 8'($urandom); train_ctrl = 8'($urandom);
    end
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, bus.sym_valid, 1'b0);
    check({tag, "_eidle"}, elec_idle, 1'b1);
    check({tag, "_sym"}, {bus.sym_k, bus.sym}, 9'h000);
    check({tag, "_done"}, os_done, 1'b0);
    check({tag, "_tscnt"}, ts_cnt, 8'd0);
  endtask

  initial begin
    logic [1:0] rq;
    bit hit;
    bus.sym_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Back-to-back TS1 with both pads set; SKPs interleave every 40 transfers.
    for (int i = 0; i < 160; i++) cyc(2'd1, 100, 0);
    check("ts1_count_reached_8", (tcnt >= 8), 1'b1);

    // Switch to TS2 while symbol 4 of a TS1 is on the bus.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(2'd1, 100, 0);
      hit = (mode == M_TS && ltype == 1 && q.size() == 12);
    end
    check("reach_ts1_sym4", hit, 1'b1);
    for (int i = 0; i < 60; i++) cyc(2'd2, 100, 1);

    // TS2 under random backpressure.
    for (int i = 0; i < 300; i++) cyc(2'd2, 60, 0);

    // Drop to IDLE, send EIOS, sit in EI, then restart training.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(2'd0, 100, 0);
      hit = (mode == M_IDLE);
    end
    check("reach_idle", hit, 1'b1);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      cyc(2'd3, 100, 0);
      hit = (mode == M_EI);
    end
    check("reach_ei", hit, 1'b1);
    for (int i = 0; i < 10; i++) cyc(2'd0, 100, 0);
    for (int i = 0; i < 5; i++) cyc(2'd3, 100, 0);
    for (int i = 0; i < 40; i++) cyc(2'd1, 100, 1);

    // Fully random traffic, requests held for a while.
    rq = 2'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4) rq = 2'($urandom);
      cyc(rq, 70, 1);
    end

    // Long TS1 run to reach saturation.
    for (int i = 0; i < 5000; i++) cyc(2'd1, 100, 0);
    check("ts_cnt_saturated", ts_cnt, 8'd255);

    // Asynchronous reset while TS symbol 9 is on the bus.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(2'd1, 100, 0);
      hit = (mode == M_TS && q.size() == 7);
    end
    check("reach_ts_sym9", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midset_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) cyc(2'd1, 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
